// File: rtl/serv_wb_bus_bridge.sv
// rtl/serv_wb_bus_bridge.sv - SERV ibus/dbus to single Wishbone core bus bridge with byte-store RMW
// Optional feature macro: SERV_BUS_TIMEOUT_EN (bus watchdog, sticky timeout_o).
module serv_wb_bus_bridge #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                    clk,
    input  logic                    rst_n,
    // SERV instruction bus
    input  logic [ADDR_WIDTH-1:0]   ibus_adr_i,
    input  logic                    ibus_cyc_i,
    output logic [DATA_WIDTH-1:0]   ibus_rdt_o,
    output logic                    ibus_ack_o,
    // SERV data bus
    input  logic [ADDR_WIDTH-1:0]   dbus_adr_i,
    input  logic [DATA_WIDTH-1:0]   dbus_dat_i,
    input  logic [DATA_WIDTH/8-1:0] dbus_sel_i,
    input  logic                    dbus_we_i,
    input  logic                    dbus_cyc_i,
    output logic [DATA_WIDTH-1:0]   dbus_rdt_o,
    output logic                    dbus_ack_o,
    // Controller core bus (no byte enables)
    output logic                    core_cyc_o,
    output logic                    core_stb_o,
    output logic                    core_we_o,
    output logic [ADDR_WIDTH-1:0]   core_addr_o,
    output logic [DATA_WIDTH-1:0]   core_data_o,
    input  logic [DATA_WIDTH-1:0]   core_data_i,
    input  logic                    core_ack_i,
    output logic                    timeout_o
);

    localparam int LANES = DATA_WIDTH / 8;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_IFETCH = 3'd1,
        S_DREAD  = 3'd2,
        S_DWRITE = 3'd3,
        S_RMW_RD = 3'd4,
        S_RMW_WR = 3'd5,
        S_COOL   = 3'd6
    } state_t;

    state_t                  r_state;
    logic                    r_cyc;
    logic                    r_we;
    logic [ADDR_WIDTH-1:0]   r_addr;
    logic [DATA_WIDTH-1:0]   r_wdata;
    logic [DATA_WIDTH-1:0]   r_dat;
    logic [LANES-1:0]        r_sel;
    logic [DATA_WIDTH-1:0]   r_ibus_rdt;
    logic                    r_ibus_ack;
    logic [DATA_WIDTH-1:0]   r_dbus_rdt;
    logic                    r_dbus_ack;

    logic                    w_ack;
    logic                    w_tmo;
    logic [DATA_WIDTH-1:0]   w_merged;
    logic                    w_unused;

    // A slave ack only counts while we are actually strobing.
    assign w_ack = r_cyc & core_ack_i;

    // Byte-lane merge of the stored data over the word just read back.
    always_comb begin
        w_merged = core_data_i;
        for (int b = 0; b < LANES; b++) begin
            if (r_sel[b]) begin
                w_merged[8*b +: 8] = r_dat[8*b +: 8];
            end
        end
    end

`ifdef SERV_BUS_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] r_tmo_cnt;
    logic          r_timeout;

    assign w_tmo     = (r_tmo_cnt == CW'(TIMEOUT_CYCLES - 1)) & ~w_ack;
    assign timeout_o = r_timeout;

    // Watchdog counter: cleared on every state change, counts while in a bus state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tmo_cnt <= '0;
            r_timeout <= 1'b0;
        end else begin
            case (r_state)
                S_IFETCH, S_DREAD, S_DWRITE, S_RMW_RD, S_RMW_WR: begin
                    if (w_ack || w_tmo) begin
                        r_tmo_cnt <= '0;
                    end else begin
                        r_tmo_cnt <= r_tmo_cnt + 1'b1;
                    end
                    if (w_tmo) begin
                        r_timeout <= 1'b1;
                    end
                end
                default: r_tmo_cnt <= '0;
            endcase
        end
    end
`else
    assign w_tmo     = 1'b0;
    assign timeout_o = 1'b0;
`endif

    assign w_unused = &{1'b0, ibus_adr_i[1:0], dbus_adr_i[1:0], (TIMEOUT_CYCLES > 0)};

    // Main bridge FSM: arbitration, bus sequencing, RMW and requester acks.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_cyc      <= 1'b0;
            r_we       <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_dat      <= '0;
            r_sel      <= '0;
            r_ibus_rdt <= '0;
            r_ibus_ack <= 1'b0;
            r_dbus_rdt <= '0;
            r_dbus_ack <= 1'b0;
        end else begin
            r_ibus_ack <= 1'b0;
            r_dbus_ack <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (dbus_cyc_i) begin
                        r_addr <= {dbus_adr_i[ADDR_WIDTH-1:2], 2'b00};
                        r_dat  <= dbus_dat_i;
                        r_sel  <= dbus_sel_i;
                        if (!dbus_we_i) begin
                            r_cyc   <= 1'b1;
                            r_we    <= 1'b0;
                            r_wdata <= '0;
                            r_state <= S_DREAD;
                        end else if (&dbus_sel_i) begin
                            r_cyc   <= 1'b1;
                            r_we    <= 1'b1;
                            r_wdata <= dbus_dat_i;
                            r_state <= S_DWRITE;
                        end else if (|dbus_sel_i) begin
                            r_cyc   <= 1'b1;
                            r_we    <= 1'b0;
                            r_wdata <= '0;
                            r_state <= S_RMW_RD;
                        end else begin
                            // Nothing to write: ack without touching the bus.
                            r_dbus_ack <= 1'b1;
                            r_state    <= S_COOL;
                        end
                    end else if (ibus_cyc_i) begin
                        r_addr  <= {ibus_adr_i[ADDR_WIDTH-1:2], 2'b00};
                        r_cyc   <= 1'b1;
                        r_we    <= 1'b0;
                        r_wdata <= '0;
                        r_state <= S_IFETCH;
                    end
                end
                S_IFETCH: begin
                    if (w_ack || w_tmo) begin
                        r_cyc <= 1'b0;
                        if (ibus_cyc_i) begin
                            r_ibus_ack <= 1'b1;
                            r_ibus_rdt <= w_ack ? core_data_i : '0;
                        end
                        r_state <= S_COOL;
                    end
                end
                S_DREAD: begin
                    if (w_ack || w_tmo) begin
                        r_cyc <= 1'b0;
                        if (dbus_cyc_i) begin
                            r_dbus_ack <= 1'b1;
                            r_dbus_rdt <= w_ack ? core_data_i : '0;
                        end
                        r_state <= S_COOL;
                    end
                end
                S_DWRITE: begin
                    if (w_ack || w_tmo) begin
                        r_cyc <= 1'b0;
                        r_we  <= 1'b0;
                        if (dbus_cyc_i) begin
                            r_dbus_ack <= 1'b1;
                            if (w_tmo) begin
                                r_dbus_rdt <= '0;
                            end
                        end
                        r_state <= S_COOL;
                    end
                end
                S_RMW_RD: begin
                    if (w_ack) begin
                        // Drop strobe for one cycle, then write the merged word.
                        r_cyc   <= 1'b0;
                        r_wdata <= w_merged;
                        r_state <= S_RMW_WR;
                    end else if (w_tmo) begin
                        r_cyc <= 1'b0;
                        if (dbus_cyc_i) begin
                            r_dbus_ack <= 1'b1;
                            r_dbus_rdt <= '0;
                        end
                        r_state <= S_COOL;
                    end
                end
                S_RMW_WR: begin
                    if (w_ack || w_tmo) begin
                        r_cyc <= 1'b0;
                        r_we  <= 1'b0;
                        if (dbus_cyc_i) begin
                            r_dbus_ack <= 1'b1;
                            if (w_tmo) begin
                                r_dbus_rdt <= '0;
                            end
                        end
                        r_state <= S_COOL;
                    end else if (!r_cyc) begin
                        r_cyc <= 1'b1;
                        r_we  <= 1'b1;
                    end
                end
                S_COOL: begin
                    // Give SERV a cycle to drop cyc after its ack.
                    r_state <= S_IDLE;
                end
                default: begin
                    r_cyc   <= 1'b0;
                    r_we    <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign core_cyc_o  = r_cyc;
    assign core_stb_o  = r_cyc;
    assign core_we_o   = r_we;
    assign core_addr_o = r_addr;
    assign core_data_o = r_wdata;
    assign ibus_rdt_o  = r_ibus_rdt;
    assign ibus_ack_o  = r_ibus_ack;
    assign dbus_rdt_o  = r_dbus_rdt;
    assign dbus_ack_o  = r_dbus_ack;

endmodule

// File: tb/tb_serv_wb_bus_bridge.sv
// tb/tb_serv_wb_bus_bridge.sv - directed table-driven bench for serv_wb_bus_bridge
module tb_serv_wb_bus_bridge;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] ibus_adr_i = '0;
    logic        ibus_cyc_i = 1'b0;
    logic [31:0] ibus_rdt_o;
    logic        ibus_ack_o;
    logic [31:0] dbus_adr_i = '0;
    logic [31:0] dbus_dat_i = '0;
    logic [3:0]  dbus_sel_i = '0;
    logic        dbus_we_i = 1'b0;
    logic        dbus_cyc_i = 1'b0;
    logic [31:0] dbus_rdt_o;
    logic        dbus_ack_o;
    logic        core_cyc_o;
    logic        core_stb_o;
    logic        core_we_o;
    logic [31:0] core_addr_o;
    logic [31:0] core_data_o;
    logic [31:0] core_data_i = '0;
    logic        core_ack_i = 1'b0;
    logic        timeout_o;

    serv_wb_bus_bridge #(
        .ADDR_WIDTH(32),
        .DATA_WIDTH(32),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .ibus_adr_i(ibus_adr_i), .ibus_cyc_i(ibus_cyc_i),
        .ibus_rdt_o(ibus_rdt_o), .ibus_ack_o(ibus_ack_o),
        .dbus_adr_i(dbus_adr_i), .dbus_dat_i(dbus_dat_i), .dbus_sel_i(dbus_sel_i),
        .dbus_we_i(dbus_we_i), .dbus_cyc_i(dbus_cyc_i),
        .dbus_rdt_o(dbus_rdt_o), .dbus_ack_o(dbus_ack_o),
        .core_cyc_o(core_cyc_o), .core_stb_o(core_stb_o), .core_we_o(core_we_o),
        .core_addr_o(core_addr_o), .core_data_o(core_data_o),
        .core_data_i(core_data_i), .core_ack_i(core_ack_i),
        .timeout_o(timeout_o)
    );

    always #5 clk = ~clk;

    // Zero-wait Wishbone slave: acks the cycle after it sees stb.
    logic [31:0] mem [0:255];
    logic        pre_en = 1'b0;
    logic [7:0]  pre_idx = '0;
    logic [31:0] pre_val = '0;
    logic        s_noack = 1'b0;
    int          rd_cnt = 0;
    int          wr_cnt = 0;
    logic [31:0] last_addr = '0;

    always @(posedge clk) begin
        if (pre_en) mem[pre_idx] <= pre_val;
        if (core_cyc_o && core_stb_o && !core_ack_i && !s_noack) begin
            core_ack_i <= 1'b1;
            last_addr  <= core_addr_o;
            if (core_we_o) begin
                mem[core_addr_o[9:2]] <= core_data_o;
                wr_cnt <= wr_cnt + 1;
            end else begin
                core_data_i <= mem[core_addr_o[9:2]];
                rd_cnt <= rd_cnt + 1;
            end
        end else begin
            core_ack_i <= 1'b0;
        end
    end

    // Protocol monitor: cyc==stb, never two acks at once.
    int mon_bad = 0;
    int stb_cnt = 0;
    always @(negedge clk) begin
        if (core_cyc_o !== core_stb_o) mon_bad <= mon_bad + 1;
        if (ibus_ack_o && dbus_ack_o) mon_bad <= mon_bad + 1;
        if (core_stb_o) stb_cnt <= stb_cnt + 1;
    end

    int total = 0;
    int bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic preload(input logic [31:0] adr, input logic [31:0] val);
        @(negedge clk);
        pre_en  = 1'b1;
        pre_idx = adr[9:2];
        pre_val = val;
        @(negedge clk);
        pre_en  = 1'b0;
    endtask

    task automatic run_req(input logic is_d, input logic we, input logic [31:0] adr,
                           input logic [31:0] dat, input logic [3:0] sel,
                           output int lat, output logic other_ack);
        @(negedge clk);
        if (is_d) begin
            dbus_adr_i = adr; dbus_dat_i = dat; dbus_sel_i = sel;
            dbus_we_i = we; dbus_cyc_i = 1'b1;
        end else begin
            ibus_adr_i = adr; ibus_cyc_i = 1'b1;
        end
        lat = 0;
        other_ack = 1'b0;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (is_d ? dbus_ack_o : ibus_ack_o) begin
                lat = n;
                other_ack = is_d ? ibus_ack_o : dbus_ack_o;
                break;
            end
        end
        if (is_d) dbus_cyc_i = 1'b0;
        else      ibus_cyc_i = 1'b0;
    endtask

    typedef struct {
        logic        is_d;
        logic        we;
        logic [31:0] adr;
        logic [31:0] dat;
        logic [3:0]  sel;
        logic [31:0] init;
        logic [31:0] exp_rdt;
        logic [31:0] exp_mem;
        int          exp_rd;
        int          exp_wr;
        int          exp_lat;
        logic [31:0] exp_a;
    } vec_t;

    vec_t vt [7];

    initial begin
        int          lat;
        int          lat2;
        logic        oth;
        int          rd0;
        int          wr0;
        int          st0;
        logic        seen;

        vt[0] = '{1'b0, 1'b0, 32'h0000_0104, 32'h0,          4'h0, 32'h0000_0013, 32'h0000_0013, 32'h0000_0013, 1, 0, 3, 32'h104};
        vt[1] = '{1'b1, 1'b0, 32'h0000_0200, 32'h0,          4'hF, 32'hCAFE_F00D, 32'hCAFE_F00D, 32'hCAFE_F00D, 1, 0, 3, 32'h200};
        vt[2] = '{1'b1, 1'b1, 32'h0000_0101, 32'h0000_AB00, 4'h2, 32'h1122_3344, 32'h0,         32'h1122_AB44, 1, 1, 6, 32'h100};
        vt[3] = '{1'b1, 1'b1, 32'h0000_0300, 32'hDEAD_BEEF, 4'hF, 32'h0000_0000, 32'h0,         32'hDEAD_BEEF, 0, 1, 3, 32'h300};
        vt[4] = '{1'b1, 1'b1, 32'h0000_0300, 32'h1234_5678, 4'h0, 32'h5555_5555, 32'h0,         32'h5555_5555, 0, 0, 1, 32'h0};
        vt[5] = '{1'b1, 1'b1, 32'h0000_0102, 32'h7788_0000, 4'hC, 32'hAAAA_BBBB, 32'h0,         32'h7788_BBBB, 1, 1, 6, 32'h100};
        vt[6] = '{1'b1, 1'b1, 32'h0000_010C, 32'h9900_0066, 4'h9, 32'h1234_5678, 32'h0,         32'h9934_5666, 1, 1, 6, 32'h10C};

        // Reset state
        @(posedge clk);
        @(negedge clk);
        chk("reset_outputs",
            {core_cyc_o, core_stb_o, core_we_o, ibus_ack_o, dbus_ack_o, timeout_o},
            32'h0);
        chk("reset_addr", core_addr_o, 32'h0);
        chk("reset_rdt", ibus_rdt_o | dbus_rdt_o, 32'h0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Table-driven single transactions
        for (int i = 0; i < 7; i++) begin
            preload(vt[i].adr, vt[i].init);
            rd0 = rd_cnt;
            wr0 = wr_cnt;
            run_req(vt[i].is_d, vt[i].we, vt[i].adr, vt[i].dat, vt[i].sel, lat, oth);
            chk($sformatf("v%0d_latency", i), lat, vt[i].exp_lat);
            chk($sformatf("v%0d_other_ack", i), {31'b0, oth}, 32'h0);
            if (!vt[i].we)
                chk($sformatf("v%0d_rdt", i), vt[i].is_d ? dbus_rdt_o : ibus_rdt_o, vt[i].exp_rdt);
            @(negedge clk);
            chk($sformatf("v%0d_ack_pulse", i), {31'b0, vt[i].is_d ? dbus_ack_o : ibus_ack_o}, 32'h0);
            chk($sformatf("v%0d_cool_idle", i), {31'b0, core_cyc_o}, 32'h0);
            repeat (2) @(negedge clk);
            chk($sformatf("v%0d_mem", i), mem[vt[i].adr[9:2]], vt[i].exp_mem);
            chk($sformatf("v%0d_reads", i), rd_cnt - rd0, vt[i].exp_rd);
            chk($sformatf("v%0d_writes", i), wr_cnt - wr0, vt[i].exp_wr);
            if (vt[i].exp_rd + vt[i].exp_wr > 0)
                chk($sformatf("v%0d_addr", i), last_addr, vt[i].exp_a);
        end

        // Arbitration: both requests in the same cycle, dbus wins
        @(negedge clk);
        ibus_adr_i = 32'h104; ibus_cyc_i = 1'b1;
        dbus_adr_i = 32'h200; dbus_we_i = 1'b0; dbus_sel_i = 4'hF; dbus_cyc_i = 1'b1;
        lat = 0;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (ibus_ack_o || dbus_ack_o) begin lat = n; break; end
        end
        chk("arb_first_is_dbus", {30'b0, ibus_ack_o, dbus_ack_o}, 32'h1);
        chk("arb_dbus_latency", lat, 3);
        chk("arb_dbus_addr", last_addr, 32'h200);
        chk("arb_dbus_rdt", dbus_rdt_o, 32'hCAFE_F00D);
        dbus_cyc_i = 1'b0;
        lat2 = 0;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (ibus_ack_o) begin lat2 = n; break; end
        end
        ibus_cyc_i = 1'b0;
        chk("arb_ibus_after_cool", lat2, 4);
        chk("arb_ibus_rdt", ibus_rdt_o, 32'h0000_0013);
        chk("arb_ibus_addr", last_addr, 32'h104);
        repeat (3) @(negedge clk);

        // Requester drops cyc mid-transaction: bus cycle completes, no ack
        preload(32'h200, 32'h0BAD_0BAD);
        rd0 = rd_cnt;
        @(negedge clk);
        dbus_adr_i = 32'h200; dbus_we_i = 1'b0; dbus_sel_i = 4'hF; dbus_cyc_i = 1'b1;
        @(negedge clk);
        dbus_cyc_i = 1'b0;
        seen = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (dbus_ack_o) seen = 1'b1;
        end
        chk("drop_no_ack", {31'b0, seen}, 32'h0);
        chk("drop_bus_completed", rd_cnt - rd0, 1);
        chk("drop_rdt_held", dbus_rdt_o, 32'hCAFE_F00D);

        // Reset asserted during RMW_RD with stb high
        preload(32'h100, 32'h1122_3344);
        wr0 = wr_cnt;
        @(negedge clk);
        dbus_adr_i = 32'h101; dbus_dat_i = 32'h0000_AB00; dbus_sel_i = 4'h2;
        dbus_we_i = 1'b1; dbus_cyc_i = 1'b1;
        seen = 1'b0;
        for (int n = 0; n < 5; n++) begin
            @(negedge clk);
            if (core_stb_o) begin seen = 1'b1; break; end
        end
        chk("rst_saw_stb", {31'b0, seen}, 32'h1);
        rst_n = 1'b0;
        #1;
        chk("rst_async_ctrl",
            {core_cyc_o, core_stb_o, core_we_o, ibus_ack_o, dbus_ack_o, timeout_o},
            32'h0);
        chk("rst_async_addr", core_addr_o, 32'h0);
        chk("rst_async_rdt", ibus_rdt_o | dbus_rdt_o, 32'h0);
        dbus_cyc_i = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        chk("rst_no_write", wr_cnt - wr0, 0);
        chk("rst_mem_intact", mem[8'h40], 32'h1122_3344);
        run_req(1'b0, 1'b0, 32'h104, 32'h0, 4'h0, lat, oth);
        chk("rst_fetch_latency", lat, 3);
        chk("rst_fetch_rdt", ibus_rdt_o, 32'h0000_0013);
        repeat (3) @(negedge clk);

`ifdef SERV_BUS_TIMEOUT_EN
        // Watchdog: slave never acks a load
        s_noack = 1'b1;
        st0 = stb_cnt;
        run_req(1'b1, 1'b0, 32'h200, 32'h0, 4'hF, lat, oth);
        chk("tmo_ack_latency", lat, 17);
        chk("tmo_stb_cycles", stb_cnt - st0, 16);
        chk("tmo_rdt_zero", dbus_rdt_o, 32'h0);
        chk("tmo_flag", {31'b0, timeout_o}, 32'h1);
        s_noack = 1'b0;
        repeat (5) @(negedge clk);
        run_req(1'b0, 1'b0, 32'h104, 32'h0, 4'h0, lat, oth);
        chk("tmo_recover_fetch", ibus_rdt_o, 32'h0000_0013);
        repeat (3) @(negedge clk);
        chk("tmo_flag_sticky", {31'b0, timeout_o}, 32'h1);
`else
        st0 = stb_cnt;
        chk("no_timeout_flag", {31'b0, timeout_o}, 32'h0);
`endif

        chk("protocol_monitor", mon_bad, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
